keypad_scan_cntr: RTL and testbench

- Input-side counterpart of the 4-digit FND scanner: it scans a 4x4 matrix keypad instead of a display.
- Drives one row at a time, samples the four column lines and debounces in units of row periods.
- Outputs a 4-bit key code, a 1-cycle key_valid pulse per accepted press, and a key_held level.
- Feeds watch/stopwatch control logic as a replacement for the discrete button_cntr inputs.

---
 rtl/keypad_scan_cntr_pkg.sv | 36 +++
 rtl/keypad_scan_cntr_if.sv | 26 ++
 rtl/keypad_scan_cntr_sync_2ff.sv | 26 ++
 rtl/keypad_scan_cntr.sv | 154 +++++++++++++++
 tb/tb_keypad_scan_cntr.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/keypad_scan_cntr_pkg.sv
// Shared types, sizes and helpers for the 4x4 matrix keypad scanner.
package keypad_scan_cntr_pkg;

  localparam int unsigned KEY_W     = 4;
  localparam int unsigned ROWS      = 4;
  localparam int unsigned COLS      = 4;
  localparam int unsigned ROW_IDX_W = $clog2(ROWS);
  localparam int unsigned COL_IDX_W = $clog2(COLS);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  // Index of the lowest set column; several keys in one row resolve to the lowest.
  function automatic logic [COL_IDX_W-1:0] lowest_col_idx(input logic [COLS-1:0] c);
    lowest_col_idx = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (c[i]) lowest_col_idx = COL_IDX_W'(i);
    end
  endfunction

  function automatic logic [ROW_IDX_W-1:0] onehot_row_idx(input logic [ROWS-1:0] r);
    onehot_row_idx = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (r[i]) onehot_row_idx = ROW_IDX_W'(i);
    end
  endfunction

  function automatic logic [ROWS-1:0] rotl_row(input logic [ROWS-1:0] r);
    rotl_row = {r[ROWS-2:0], r[ROWS-1]};
  endfunction

endpackage

// File: rtl/keypad_scan_cntr_if.sv
// Keypad-side signals: row drive and column sense plus the decoded key outputs.
interface keypad_scan_cntr_if;
  import keypad_scan_cntr_pkg::*;

  logic [COLS-1:0]  col;
  logic [ROWS-1:0]  row;
  logic [KEY_W-1:0] key_value;
  logic             key_valid;
  logic             key_held;

  modport master (
    input  col,
    output row,
    output key_value,
    output key_valid,
    output key_held
  );

  modport slave (
    output col,
    input  row,
    input  key_value,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scan_cntr_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs (keypad columns, raw buttons).
module keypad_scan_cntr_sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_cntr.sv
// 4x4 keypad scanner: one-hot row drive, column sampling once per row period,
// press/release debounce counted in row periods.
module keypad_scan_cntr
  import keypad_scan_cntr_pkg::*;
#(
  parameter int unsigned ROW_TICKS = 10000,
  parameter int unsigned DEB_COUNT = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  keypad_scan_cntr_if.master        kp
);

  localparam int unsigned TICK_W = $clog2(ROW_TICKS);
  // One extra bit of headroom so the counters can actually hold DEB_COUNT.
  localparam int unsigned CNT_W  = $clog2(DEB_COUNT + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(ROW_TICKS - 1);
  localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEB_COUNT);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam bit                ONE_SHOT  = (DEB_COUNT <= 1);

  state_e           state_q, state_d;
  logic [ROWS-1:0]  row_q, row_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0] rel_cnt_q, rel_cnt_d;
  logic [COLS-1:0]  cap_col_q, cap_col_d;
  logic [KEY_W-1:0] key_value_q, key_value_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;

  logic [COLS-1:0]  col_s;
  logic             sample_c;
  logic [CNT_W-1:0] deb_inc_c;
  logic [CNT_W-1:0] rel_inc_c;

  keypad_scan_cntr_sync_2ff #(
    .WIDTH (COLS)
  ) u_col_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d_i   (kp.col),
    .q_o   (col_s)
  );

  assign sample_c  = (tick_q == TICK_LAST);
  assign deb_inc_c = (deb_cnt_q < CNT_DONE) ? deb_cnt_q + CNT_ONE : deb_cnt_q;
  assign rel_inc_c = (rel_cnt_q < CNT_DONE) ? rel_cnt_q + CNT_ONE : rel_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SCAN;
      row_q       <= ROWS'(1);
      tick_q      <= '0;
      deb_cnt_q   <= '0;
      rel_cnt_q   <= '0;
      cap_col_q   <= '0;
      key_value_q <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      tick_q      <= tick_d;
      deb_cnt_q   <= deb_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      cap_col_q   <= cap_col_d;
      key_value_q <= key_value_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  // Next-state logic; every decision is taken only on the row-period sample point.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    tick_d      = sample_c ? '0 : tick_q + TICK_W'(1);
    deb_cnt_d   = deb_cnt_q;
    rel_cnt_d   = rel_cnt_q;
    cap_col_d   = cap_col_q;
    key_value_d = key_value_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    if (sample_c) begin
      unique case (state_q)
        SCAN: begin
          if (col_s == '0) begin
            row_d = rotl_row(row_q);
          end else begin
            cap_col_d = col_s;
            deb_cnt_d = CNT_ONE;
            if (ONE_SHOT) begin
              state_d     = PRESSED;
              key_held_d  = 1'b1;
              key_valid_d = 1'b1;
              key_value_d = {onehot_row_idx(row_q), lowest_col_idx(col_s)};
            end else begin
              state_d = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (col_s == cap_col_q) begin
            deb_cnt_d = deb_inc_c;
            if (deb_inc_c >= CNT_DONE) begin
              state_d     = PRESSED;
              key_held_d  = 1'b1;
              key_valid_d = 1'b1;
              key_value_d = {onehot_row_idx(row_q), lowest_col_idx(cap_col_q)};
            end
          end else begin
            deb_cnt_d = '0;
            row_d     = rotl_row(row_q);
            state_d   = SCAN;
          end
        end
        PRESSED: begin
          if (col_s == '0) begin
            rel_cnt_d = CNT_ONE;
            if (ONE_SHOT) begin
              key_held_d = 1'b0;
              row_d      = rotl_row(row_q);
              state_d    = SCAN;
            end else begin
              state_d = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (col_s != '0) begin
            state_d = PRESSED;
          end else begin
            rel_cnt_d = rel_inc_c;
            if (rel_inc_c >= CNT_DONE) begin
              key_held_d = 1'b0;
              row_d      = rotl_row(row_q);
              state_d    = SCAN;
            end
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  assign kp.row       = row_q;
  assign kp.key_value = key_value_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_cntr.sv
// Scoreboard bench for keypad_scan_cntr with a 4x4 key-matrix model driving col from row.
module tb_keypad_scan_cntr;

  logic clk;
  logic reset_n;
  logic [3:0] keys [4];
  logic [3:0] col_m;
  logic [3:0] exp_q [$];
  int tests;
  int fails;

  keypad_scan_cntr_if ifc ();

  keypad_scan_cntr #(
    .ROW_TICKS (4),
    .DEB_COUNT (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .kp      (ifc.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // A pressed key connects its row line to its column line.
  always_comb begin
    col_m = '0;
    for (int r = 0; r < 4; r++) begin
      if (ifc.row[r]) col_m = col_m | keys[r];
    end
  end
  assign ifc.col = col_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_row(input logic [3:0] r);
    int n = 0;
    while (ifc.row !== r && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_row", 32'(ifc.row), 32'(r));
  endtask

  task automatic wait_held(input logic v);
    int n = 0;
    while (ifc.key_held !== v && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_held", 32'(ifc.key_held), 32'(v));
  endtask

  // Monitor: every key_valid pulse must match the oldest expected code.
  initial begin
    logic prev_valid;
    logic [3:0] exp_code;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && ifc.key_valid) begin
        check("valid_single_cycle", 32'(prev_valid), 32'(0));
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_key_valid: key_value=%0h, required no pulse (t=%0t)",
                   ifc.key_value, $time);
        end else begin
          exp_code = exp_q.pop_front();
          check("key_value", 32'(ifc.key_value), 32'(exp_code));
          check("held_with_valid", 32'(ifc.key_held), 32'(1));
        end
      end
      prev_valid = reset_n && ifc.key_valid;
    end
  end

  initial begin
    logic [3:0] exp_row;
    tests   = 0;
    fails   = 0;
    reset_n = 1'b0;
    for (int r = 0; r < 4; r++) keys[r] = 4'h0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_row", 32'(ifc.row), 32'(4'b0001));
    check("rst_key_value", 32'(ifc.key_value), 32'(0));
    check("rst_key_valid", 32'(ifc.key_valid), 32'(0));
    check("rst_key_held", 32'(ifc.key_held), 32'(0));
    reset_n = 1'b1;

    // Idle scan: row advances every 4 clocks, no key activity
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      exp_row = 4'b0001 << ((k / 4) % 4);
      check("scan_row", 32'(ifc.row), 32'(exp_row));
      check("scan_no_valid", 32'(ifc.key_valid), 32'(0));
    end

    // Press row 2 / column 1 -> code 9
    exp_q.push_back(4'h9);
    keys[2] = 4'b0010;
    wait_held(1'b1);
    check("press9_row_frozen", 32'(ifc.row), 32'(4'b0100));
    repeat (8) @(negedge clk);
    check("press9_row_still", 32'(ifc.row), 32'(4'b0100));
    check("press9_held", 32'(ifc.key_held), 32'(1));

    // Release: held drops, row moves on
    keys[2] = 4'h0;
    wait_held(1'b0);
    check("rel9_row_rotated", 32'(ifc.row), 32'(4'b1000));
    check("rel9_key_value", 32'(ifc.key_value), 32'(4'h9));

    // Bounce in row 1 shorter than the debounce window
    wait_row(4'b0010);
    keys[1] = 4'b0001;
    repeat (8) @(negedge clk);
    check("bounce_row_frozen", 32'(ifc.row), 32'(4'b0010));
    keys[1] = 4'h0;
    wait_row(4'b0100);
    check("bounce_no_held", 32'(ifc.key_held), 32'(0));
    check("bounce_key_value", 32'(ifc.key_value), 32'(4'h9));

    // Two keys in row 3 -> lowest column wins, code D
    exp_q.push_back(4'hD);
    keys[3] = 4'b1010;
    wait_held(1'b1);
    check("pressD_row_frozen", 32'(ifc.row), 32'(4'b1000));
    keys[3] = 4'b0100;
    repeat (12) @(negedge clk);
    check("colchg_held", 32'(ifc.key_held), 32'(1));
    check("colchg_key_value", 32'(ifc.key_value), 32'(4'hD));
    keys[3] = 4'b1010;
    repeat (4) @(negedge clk);

    // Reset while the key is still held
    reset_n = 1'b0;
    #1;
    check("midrst_row", 32'(ifc.row), 32'(4'b0001));
    check("midrst_key_value", 32'(ifc.key_value), 32'(0));
    check("midrst_key_valid", 32'(ifc.key_valid), 32'(0));
    check("midrst_key_held", 32'(ifc.key_held), 32'(0));
    repeat (2) @(negedge clk);
    exp_q.push_back(4'hD);
    reset_n = 1'b1;
    wait_held(1'b1);
    check("redetect_key_value", 32'(ifc.key_value), 32'(4'hD));

    // Release glitch of a single sample point
    keys[3] = 4'h0;
    repeat (4) @(negedge clk);
    keys[3] = 4'b1010;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("glitch_held", 32'(ifc.key_held), 32'(1));
    end
    check("glitch_row_frozen", 32'(ifc.row), 32'(4'b1000));

    keys[3] = 4'h0;
    wait_held(1'b0);
    repeat (4) @(negedge clk);
    check("no_pending_pulses", 32'(exp_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
